min_hour_counter: RTL and testbench
===================================

# min_hour_counter

Minutes/hours stage of the digital clock, directly downstream of the seconds stage. It consumes the seconds roll-over carry, keeps BCD minutes (00–59) and hours (00–23), and drives HEX4/HEX5 (minutes) and HEX6/HEX7 (hours). It also accepts two debounced push-keys for manual time setting.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 1_000_000 (20 ms at 50 MHz): number of consecutive stable cycles a key must hold before a level change is accepted.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz; the only clock.
- reset  in  1  asynchronous, active-low reset.
- sec_carry  in  1  seconds-stage carry. Its rising edge means one minute has elapsed. It is produced in another clock domain and is treated as asynchronous.
- inc_min_n  in  1  KEY, active-low: manual minute increment.
- inc_hour_n  in  1  KEY, active-low: manual hour increment.
- min_bcd  out  8  {tens, ones} of minutes, BCD.
- hour_bcd  out  8  {tens, ones} of hours, BCD.
- HEX4, HEX5  out  7  minute ones and tens, 7-segment, active-low, bit order {g,f,e,d,c,b,a}.
- HEX6, HEX7  out  7  hour ones and tens, same encoding.
- day_carry  out  1  one-cycle pulse on automatic roll-over from 23:59 to 00:00.

## Operation
- **sec_carry input path:** 2-FF synchronizer, then a previous-value register. tick_min = synced & ~prev. A held-high level yields exactly one tick.
- **Keys:** each key passes through a 2-FF synchronizer and a debouncer holding a stable state, which resets to "released".
  - The stable state flips only after the synced level has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce clears the count.
  - A press pulse (1 cycle) fires on the stable released→pressed transition.
  - There is no auto-repeat.
- **Minute increment:** min_inc = tick_min | min_press. Simultaneous sources produce a single +1.
  - Ones 9→0 with tens+1. Tens are in 0–5.
  - 59→00 generates min_wrap, but only when tick_min is the source. A manual-only wrap does not carry.
- **Hour increment:** hour_inc = min_wrap | hour_press. Simultaneous sources produce a single +1.
  - Ones 9→0 with tens+1.
  - 23→00 wraps.
- **day_carry:** asserted for the cycle after a 23→00 wrap caused by min_wrap. It is not asserted for a manual wrap.
- **Seven-segment decode:** combinational from the registered BCD digits. Patterns are 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Any other value gives 1111111 (blank).
- **Reset values:** min_bcd=8'h00, hour_bcd=8'h00, HEX4–HEX7=7'b1000000, day_carry=0. Synchronizers, debouncers, prev and press are all cleared.
- **Reset mid-operation:** clears state immediately, without waiting for a clock edge. A sec_carry edge or key press in flight is discarded.

## Timing
- **sec_carry latency:** sec_carry rises before edge 1. Edge 1 loads sync1, edge 2 loads sync2, and min_bcd updates at edge 3. HEX4/HEX5 update in the same cycle.
- **Cascaded carries:** the hour update on minute carry occurs at the same edge as the minute wrap. There is no extra latency.
- **day_carry:** goes high in the cycle after the edge that produces 00:00 and is low again one cycle later.
- **Key latency:** the key falls before edge 1. The press pulse occurs 2 + DEBOUNCE_CYCLES edges later, and the counter updates on the following edge.
- **sec_carry spacing:** successive rising edges must be separated by at least 3 CLOCK_50 cycles low. Edges spaced closer than this are not guaranteed to be counted.

## Structure
- **Shared package:** the BCD digit type (4 bits), the seven-segment pattern constants SEG_0..SEG_9 and SEG_BLANK, and the limits MIN_TENS_MAX=5 and HOUR_MAX=23.
- **Sub-module:** key_debounce (parameter DEBOUNCE_CYCLES; ports CLOCK_50, reset, key_n, press), instantiated twice.
- **Top level:** sync/edge logic, the BCD counters and the four decoders are inline.

## Test plan
Bench uses DEBOUNCE_CYCLES=4.
1. **Reset:** assert reset mid-count at 12:34 → all outputs at reset values immediately. After release, min_bcd=8'h00, hour_bcd=8'h00, HEX4–HEX7=7'b1000000.
2. **Minute counting:** 59 sec_carry pulses → min_bcd=8'h59, HEX5=0010010, HEX4=0010000. One more pulse → min_bcd=8'h00, hour_bcd=8'h01, HEX6=1111001.
3. **Day roll-over:** set 23:59 with keys (23 hour presses, 59 minute presses), then one sec_carry pulse → 00:00 with day_carry high for exactly 1 cycle. sec_carry held high 50 cycles → exactly one tick.
4. **Manual wraps:** minute press at xx:59 → minutes 00, hours unchanged. Hour press at 23 → 00 with day_carry=0.
5. **Simultaneous sources:**
   - tick_min and min_press in the same cycle at 10:20 → 10:21.
   - tick_min at 10:59 with hour_press in the same cycle → 11:00 (not 12:00).
6. **Debounce:**
   - inc_min_n low for 3 cycles → no change.
   - Low for 4 or more cycles → +1.
   - Held low 100 cycles → exactly +1.
   - 1-cycle high glitches during the hold → no extra increments.

Source files
------------

// File: rtl/min_hour_counter_pkg.sv
// min_hour_counter_pkg: BCD digit type, 7-segment patterns, counter limits and decoder
package min_hour_counter_pkg;
  typedef logic [3:0] bcd_t;
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam bcd_t MIN_TENS_MAX = 4'd5;
  localparam logic [7:0] HOUR_MAX = 8'h23;
  function automatic logic [6:0] seg7(bcd_t d);
    case (d)
      4'd0: return SEG_0;
      4'd1: return SEG_1;
      4'd2: return SEG_2;
      4'd3: return SEG_3;
      4'd4: return SEG_4;
      4'd5: return SEG_5;
      4'd6: return SEG_6;
      4'd7: return SEG_7;
      4'd8: return SEG_8;
      4'd9: return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction
endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-FF sync of active-low key_n, debounced stable level, 1-cycle press pulse on release->press
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic key_n,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic s1, s2, stable, flip;
  logic [CW-1:0] cnt;
  assign flip = (s2 != stable) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  always_ff @(posedge CLOCK_50 or negedge reset)
    if (!reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      stable <= 1'b1;
      cnt <= '0;
      press <= 1'b0;
    end else begin
      s1 <= key_n;
      s2 <= s1;
      cnt <= (s2 == stable || flip) ? '0 : cnt + CW'(1);
      stable <= flip ? s2 : stable;
      press <= flip & stable;
    end
endmodule

// File: rtl/min_hour_counter.sv
// min_hour_counter: BCD minutes/hours from sec_carry edges and debounced set keys, driving HEX4-HEX7 and day_carry
module min_hour_counter
  import min_hour_counter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       sec_carry,
  input  logic       inc_min_n,
  input  logic       inc_hour_n,
  output logic [7:0] min_bcd,
  output logic [7:0] hour_bcd,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5,
  output logic [6:0] HEX6,
  output logic [6:0] HEX7,
  output logic       day_carry
);
  logic sc1, sc2, sc_prev, tick_min, min_press, hour_press, min_inc, min_wrap, hour_inc;
  logic [7:0] min_nxt, hour_nxt;
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_min_key (
    .CLOCK_50(CLOCK_50), .reset(reset), .key_n(inc_min_n), .press(min_press)
  );
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_hour_key (
    .CLOCK_50(CLOCK_50), .reset(reset), .key_n(inc_hour_n), .press(hour_press)
  );
  assign tick_min = sc2 & ~sc_prev;
  assign min_inc = tick_min | min_press;
  assign min_wrap = tick_min && (min_bcd == {MIN_TENS_MAX, 4'd9});
  assign hour_inc = min_wrap | hour_press;
  assign min_nxt = (min_bcd[3:0] != 4'd9) ? {min_bcd[7:4], min_bcd[3:0] + 4'd1} :
                   (min_bcd[7:4] == MIN_TENS_MAX) ? 8'h00 : {min_bcd[7:4] + 4'd1, 4'd0};
  assign hour_nxt = (hour_bcd == HOUR_MAX) ? 8'h00 :
                    (hour_bcd[3:0] == 4'd9) ? {hour_bcd[7:4] + 4'd1, 4'd0} :
                    {hour_bcd[7:4], hour_bcd[3:0] + 4'd1};
  always_ff @(posedge CLOCK_50 or negedge reset)
    if (!reset) begin
      sc1 <= 1'b0;
      sc2 <= 1'b0;
      sc_prev <= 1'b0;
      min_bcd <= 8'h00;
      hour_bcd <= 8'h00;
      day_carry <= 1'b0;
    end else begin
      sc1 <= sec_carry;
      sc2 <= sc1;
      sc_prev <= sc2;
      min_bcd <= min_inc ? min_nxt : min_bcd;
      hour_bcd <= hour_inc ? hour_nxt : hour_bcd;
      day_carry <= min_wrap && (hour_bcd == HOUR_MAX);
    end
  assign HEX4 = seg7(min_bcd[3:0]);
  assign HEX5 = seg7(min_bcd[7:4]);
  assign HEX6 = seg7(hour_bcd[3:0]);
  assign HEX7 = seg7(hour_bcd[7:4]);
endmodule

// File: tb/tb_min_hour_counter.sv
// tb_min_hour_counter: scoreboard bench for min_hour_counter with DEBOUNCE_CYCLES=4
module tb_min_hour_counter;
  typedef struct {
    string      tag;
    logic [7:0] mn;
    logic [7:0] hr;
  } exp_t;
  logic CLOCK_50 = 1'b0, reset = 1'b0, sec_carry = 1'b0, inc_min_n = 1'b1, inc_hour_n = 1'b1;
  logic [7:0] min_bcd, hour_bcd;
  logic [6:0] HEX4, HEX5, HEX6, HEX7;
  logic day_carry;
  int n_vec = 0, n_err = 0, day_cnt = 0, m_min = 0, m_hour = 0;
  exp_t sb[$];
  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  min_hour_counter #(.DEBOUNCE_CYCLES(4)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .sec_carry(sec_carry), .inc_min_n(inc_min_n),
    .inc_hour_n(inc_hour_n), .min_bcd(min_bcd), .hour_bcd(hour_bcd), .HEX4(HEX4), .HEX5(HEX5),
    .HEX6(HEX6), .HEX7(HEX7), .day_carry(day_carry)
  );
  always #5 CLOCK_50 = ~CLOCK_50;
  always @(negedge CLOCK_50) if (day_carry === 1'b1) day_cnt++;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] to_bcd(int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction
  task automatic cyc(int n);
    repeat (n) @(negedge CLOCK_50);
  endtask
  task automatic m_hour_inc();
    m_hour = (m_hour == 23) ? 0 : m_hour + 1;
  endtask
  task automatic m_min_inc(bit from_tick);
    if (m_min == 59) begin
      m_min = 0;
      if (from_tick) m_hour_inc();
    end else m_min++;
  endtask
  task automatic push_exp(string tag);
    exp_t e;
    e.tag = tag;
    e.mn = to_bcd(m_min);
    e.hr = to_bcd(m_hour);
    sb.push_back(e);
  endtask
  task automatic pop_cmp();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    chk({e.tag, ".min"}, min_bcd, e.mn);
    chk({e.tag, ".hour"}, hour_bcd, e.hr);
    chk({e.tag, ".HEX4"}, HEX4, seg_tab[e.mn[3:0]]);
    chk({e.tag, ".HEX5"}, HEX5, seg_tab[e.mn[7:4]]);
    chk({e.tag, ".HEX6"}, HEX6, seg_tab[e.hr[3:0]]);
    chk({e.tag, ".HEX7"}, HEX7, seg_tab[e.hr[7:4]]);
    chk({e.tag, ".day"}, day_carry, 0);
  endtask
  task automatic verify(string tag);
    push_exp(tag);
    pop_cmp();
  endtask
  task automatic sec_pulse(int hi);
    sec_carry = 1'b1;
    cyc(hi);
    sec_carry = 1'b0;
    cyc(4);
    m_min_inc(1);
  endtask
  task automatic key_hold(bit hr, int low);
    if (hr) inc_hour_n = 1'b0; else inc_min_n = 1'b0;
    cyc(low);
    inc_hour_n = 1'b1;
    inc_min_n = 1'b1;
    cyc(10);
  endtask
  task automatic press_n(bit hr, int n);
    for (int i = 0; i < n; i++) begin
      key_hold(hr, 6);
      if (hr) m_hour_inc(); else m_min_inc(0);
    end
  endtask
  task automatic combo(bit hr);
    if (hr) inc_hour_n = 1'b0; else inc_min_n = 1'b0;
    cyc(4);
    sec_carry = 1'b1;
    cyc(3);
    sec_carry = 1'b0;
    inc_hour_n = 1'b1;
    inc_min_n = 1'b1;
    cyc(12);
  endtask
  task automatic do_reset();
    reset = 1'b0;
    cyc(3);
    reset = 1'b1;
    cyc(2);
    m_min = 0;
    m_hour = 0;
  endtask
  initial begin
    cyc(1);
    do_reset();
    verify("reset_init");
    press_n(1, 12);
    press_n(0, 34);
    verify("set_12_34");
    inc_min_n = 1'b0;
    cyc(2);
    #2 reset = 1'b0;
    #1;
    m_min = 0;
    m_hour = 0;
    verify("async_reset");
    inc_min_n = 1'b1;
    cyc(2);
    reset = 1'b1;
    cyc(10);
    verify("post_reset");
    for (int i = 0; i < 59; i++) begin
      sec_pulse(3);
      if (i % 10 == 0) verify("min_count");
    end
    verify("min_59");
    sec_pulse(3);
    verify("min_wrap_01_00");
    do_reset();
    press_n(1, 23);
    press_n(0, 59);
    verify("set_23_59");
    day_cnt = 0;
    sec_pulse(3);
    verify("day_rollover");
    chk("day_carry_cycles", day_cnt, 1);
    sec_pulse(50);
    verify("held_sec_one_tick");
    chk("day_carry_after_hold", day_cnt, 1);
    press_n(0, 58);
    verify("set_00_59");
    press_n(0, 1);
    verify("manual_min_wrap");
    press_n(1, 23);
    verify("set_hour_23");
    day_cnt = 0;
    press_n(1, 1);
    verify("manual_hour_wrap");
    chk("manual_wrap_day", day_cnt, 0);
    press_n(1, 10);
    press_n(0, 20);
    verify("set_10_20");
    combo(0);
    m_min_inc(1);
    verify("tick_and_min_press");
    press_n(0, 38);
    verify("set_10_59");
    combo(1);
    m_min = 0;
    m_hour = 11;
    verify("tick_wrap_and_hour_press");
    key_hold(0, 3);
    verify("debounce_3_low");
    key_hold(0, 4);
    m_min_inc(0);
    verify("debounce_4_low");
    key_hold(0, 100);
    m_min_inc(0);
    verify("held_100");
    inc_min_n = 1'b0;
    cyc(6);
    repeat (5) begin
      inc_min_n = 1'b1;
      cyc(1);
      inc_min_n = 1'b0;
      cyc(3);
    end
    inc_min_n = 1'b1;
    cyc(10);
    m_min_inc(0);
    verify("glitchy_hold");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
